// File: rtl/int_requester.sv
// ---------------------------------------------------------------------------
// int_requester
//
// Collects rising-edge events from four interrupt sources into a pending
// register and raises a single prioritised request toward a processor,
// using a level ack handshake and an ack timeout.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   irq_src[3:0] in   event sources (rising edge = one event), clk-synchronous
//   mask_we      in   load strobe for the mask register
//   mask_in[3:0] in   mask value, bit=1 blocks that source from requesting
//   ack          in   processor acknowledge (level)
//   interrupt    out  registered request to the processor
//   irq_id[1:0]  out  registered index of the source being requested
//   pending[3:0] out  pending-event register
//   serviced_cnt out  8-bit wrapping count of acknowledged requests
//   timeout_err  out  sticky flag: a request was abandoned without ack
// ---------------------------------------------------------------------------
module int_requester #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq_src,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  input  logic       ack,
  output logic       interrupt,
  output logic [1:0] irq_id,
  output logic [3:0] pending,
  output logic [7:0] serviced_cnt,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] irq_src_q;
  logic [3:0] mask;
  logic [7:0] tmo_cnt;

  logic [3:0] edge_evt;
  logic [3:0] eligible;
  logic [1:0] first_id;
  logic [3:0] clr;

  assign edge_evt = irq_src & ~irq_src_q;
  assign eligible = pending & ~mask;

  // Lowest index wins: scan from the top so the last hit is the lowest bit.
  always_comb begin
    first_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) first_id = i[1:0];
    end
  end

  // Pending bit of the active source is cleared only on the acknowledging edge.
  always_comb begin
    clr = 4'b0000;
    if (state == S_ASSERT && ack) clr[irq_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      irq_src_q    <= 4'b0000;
      pending      <= 4'b0000;
      mask         <= 4'b0000;
      interrupt    <= 1'b0;
      irq_id       <= 2'd0;
      serviced_cnt <= 8'd0;
      timeout_err  <= 1'b0;
      tmo_cnt      <= 8'd0;
    end else begin
      irq_src_q <= irq_src;
      // A fresh event on the source being cleared wins over the clear.
      pending   <= (pending & ~clr) | edge_evt;
      if (mask_we) mask <= mask_in;

      case (state)
        S_IDLE: begin
          if (eligible != 4'b0000) begin
            state     <= S_ASSERT;
            interrupt <= 1'b1;
            irq_id    <= first_id;
            tmo_cnt   <= 8'd0;
          end
        end

        // Mask changes are not looked at here: an issued request stays up
        // until it is acknowledged or times out.
        S_ASSERT: begin
          if (ack) begin
            state        <= S_RELEASE;
            interrupt    <= 1'b0;
            serviced_cnt <= serviced_cnt + 8'd1;
          end else if (tmo_cnt == ACK_TIMEOUT - 8'd1) begin
            // interrupt has then been high for exactly ACK_TIMEOUT cycles
            state       <= S_IDLE;
            interrupt   <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        // Wait for ack to drop so one ack pulse services exactly one request.
        S_RELEASE: begin
          if (!ack) state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule
